// File: rtl/rv_pkg.sv
// RV32I shared decode definitions: base opcode classes, shift funct3 codes
// and the decoded-field record carried through the decode stage.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SR    = 3'b101;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       illegal;
    } dec_fields_t;

    localparam int DEC_FIELDS_W = $bits(dec_fields_t);

    // Shift-immediate forms carry a zero-extended shamt instead of a signed imm.
    function automatic logic is_shift_imm(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OP_I) && ((funct3 == F3_SLL) || (funct3 == F3_SR));
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I field, control-flag and immediate extraction,
// producing an XLEN-wide extended immediate.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output dec_fields_t     fields
);

    logic [11:0] i_imm_s;
    logic [11:0] s_imm_s;
    logic [12:0] b_imm_s;
    logic [20:0] j_imm_s;
    logic [31:0] u_imm_s;
    logic        writes_class_s;

    assign i_imm_s = instr[31:20];
    assign s_imm_s = {instr[31:25], instr[11:7]};
    assign b_imm_s = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm_s = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign u_imm_s = {instr[31:12], 12'b0};

    // Classify the opcode and select the matching immediate format.
    always_comb begin
        imm              = '0;
        writes_class_s   = 1'b0;
        fields           = '0;
        fields.rs1       = instr[19:15];
        fields.rs2       = instr[24:20];
        fields.rd        = instr[11:7];
        fields.opcode    = instr[6:0];
        fields.funct3    = instr[14:12];
        fields.funct7    = instr[31:25];
        case (instr[6:0])
            OP_R: begin
                fields.uses_rs1 = 1'b1;
                fields.uses_rs2 = 1'b1;
                writes_class_s  = 1'b1;
            end
            OP_I: begin
                fields.uses_rs1 = 1'b1;
                writes_class_s  = 1'b1;
                if (is_shift_imm(instr[6:0], instr[14:12])) begin
                    imm = XLEN'(instr[20 +: SHAMT_W]);
                end else begin
                    imm = XLEN'($signed(i_imm_s));
                end
            end
            OP_LOAD, OP_JALR: begin
                fields.uses_rs1 = 1'b1;
                writes_class_s  = 1'b1;
                imm             = XLEN'($signed(i_imm_s));
            end
            OP_S: begin
                fields.uses_rs1 = 1'b1;
                fields.uses_rs2 = 1'b1;
                imm             = XLEN'($signed(s_imm_s));
            end
            OP_B: begin
                fields.uses_rs1 = 1'b1;
                fields.uses_rs2 = 1'b1;
                imm             = XLEN'($signed(b_imm_s));
            end
            OP_JAL: begin
                writes_class_s  = 1'b1;
                imm             = XLEN'($signed(j_imm_s));
            end
            OP_LUI, OP_AUIPC: begin
                writes_class_s  = 1'b1;
                imm             = XLEN'($signed(u_imm_s));
            end
            default: begin
                fields.illegal  = 1'b1;
            end
        endcase
        // Writes to x0 are architecturally discarded, so they are not flagged.
        fields.writes_rd = writes_class_s && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes on entry into a two-entry
// (main + skid) buffer with a valid/ready handshake on both sides.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic            out_writes_rd,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm_s;
    dec_fields_t     dec_fields_s;

    logic            main_valid_r;
    dec_fields_t     main_fields_r;
    logic [XLEN-1:0] main_imm_r;
    logic [PC_W-1:0] main_pc_r;
    logic            skid_valid_r;
    dec_fields_t     skid_fields_r;
    logic [XLEN-1:0] skid_imm_r;
    logic [PC_W-1:0] skid_pc_r;
    logic            in_ready_r;

    logic            accept_s;
    logic            xfer_s;
    logic            main_valid_nxt_s;
    logic            skid_valid_nxt_s;
    logic            main_load_in_s;
    logic            main_load_skid_s;
    logic            skid_load_s;

    imm_gen #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_imm_gen (
        .instr  (in_instr),
        .imm    (dec_imm_s),
        .fields (dec_fields_s)
    );

    assign accept_s = in_valid && in_ready_r;
    assign xfer_s   = main_valid_r && out_ready;

    // Buffer occupancy and load selection; flush overrides any accept.
    always_comb begin
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        main_load_in_s   = 1'b0;
        main_load_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (!main_valid_r) begin
            main_valid_nxt_s = accept_s;
            main_load_in_s   = accept_s;
        end else if (skid_valid_r) begin
            if (xfer_s) begin
                main_load_skid_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                main_load_skid_s = 1'b0;
            end
        end else begin
            if (xfer_s) begin
                main_valid_nxt_s = accept_s;
                main_load_in_s   = accept_s;
            end else begin
                skid_valid_nxt_s = accept_s;
                skid_load_s      = accept_s;
            end
        end
    end

    // Entry registers; in_ready is precomputed so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r  <= 1'b0;
            main_fields_r <= '0;
            main_imm_r    <= '0;
            main_pc_r     <= '0;
            skid_valid_r  <= 1'b0;
            skid_fields_r <= '0;
            skid_imm_r    <= '0;
            skid_pc_r     <= '0;
            in_ready_r    <= 1'b0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            if (main_load_in_s) begin
                main_fields_r <= dec_fields_s;
                main_imm_r    <= dec_imm_s;
                main_pc_r     <= in_pc;
            end else if (main_load_skid_s) begin
                main_fields_r <= skid_fields_r;
                main_imm_r    <= skid_imm_r;
                main_pc_r     <= skid_pc_r;
            end
            if (skid_load_s) begin
                skid_fields_r <= dec_fields_s;
                skid_imm_r    <= dec_imm_s;
                skid_pc_r     <= in_pc;
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = main_valid_r;
    assign out_pc        = main_pc_r;
    assign out_imm       = main_imm_r;
    assign out_rs1       = main_fields_r.rs1;
    assign out_rs2       = main_fields_r.rs2;
    assign out_rd        = main_fields_r.rd;
    assign out_opcode    = main_fields_r.opcode;
    assign out_funct3    = main_fields_r.funct3;
    assign out_funct7    = main_fields_r.funct7;
    assign out_uses_rs1  = main_fields_r.uses_rs1;
    assign out_uses_rs2  = main_fields_r.uses_rs2;
    assign out_writes_rd = main_fields_r.writes_rd;
    assign out_illegal   = main_fields_r.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised successor to the combinational RV32I field/immediate decoder. It accepts fetched instructions over a valid/ready handshake and extracts rs1, rs2, rd and the sign-extended immediate at XLEN width. It also emits per-instruction control flags: uses_rs1, uses_rs2, writes_rd and illegal. A 2-entry skid buffer provides full throughput under backpressure. It sits between fetch and execute.

Parameters:
XLEN, 32, datapath and immediate width; legal values 32 or 64
PC_W, 32, width of the PC carried alongside the instruction
SHAMT_W, $clog2(XLEN), shift-amount width extracted for SLLI/SRLI/SRAI

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction PC
flush  in  1  synchronous kill of all held entries
out_valid  out  1  decoded entry available
out_ready  in  1  execute accepts the entry
out_pc  out  PC_W  PC of the entry
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_rd  out  5  instr[11:7]
out_imm  out  XLEN  extended immediate
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_uses_rs1  out  1  rs1 is read (R, I, LOAD, S, B, JALR)
out_uses_rs2  out  1  rs2 is read (R, S, B)
out_writes_rd  out  1  rd is written (R, I, LOAD, JAL, JALR, LUI, AUIPC) and rd != 0
out_illegal  out  1  opcode is not one of the nine RV32I base classes

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset:
  - out_valid=0 and every out_* data field=0.
  - Both skid entries are invalid.
  - in_ready=1 from the first clock edge after rst deasserts.
- Acceptance rules:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency: an accepted instruction appears on out_* exactly 1 cycle later when the buffer is empty.
- Storage and ordering:
  - Decoding happens before storage; the two entries (main, skid) hold decoded fields.
  - in_ready = !skid_valid, so it is registered with no combinational path from out_ready.
  - Strict FIFO order.
  - Simultaneous accept and transfer with one entry held: occupancy unchanged, throughput 1 per cycle.
- Flush:
  - When asserted, both entries are invalidated at the edge and out_valid=0 next cycle.
  - An instruction presented in the same cycle is dropped.
  - in_ready=1 next cycle.
  - Flush has priority over accept.
- Immediate rules, all sign-extended to XLEN from the top encoded bit:
  - I-type, LOAD, JALR: instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - JAL: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - LUI/AUIPC: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - SLLI/SRLI/SRAI (opcode I-type, funct3 001/101): zero-extended instr[20+SHAMT_W-1:20]; funct7 does not enter the immediate.
  - R-type and illegal opcodes: imm=0.
- Illegal opcode:
  - out_illegal=1, all use/write flags=0, entry still flows through so execute can trap.
- Register-field outputs are raw bit slices, independent of format.

Decomposition:
- Shared package rv_pkg:
  - Opcode constants: R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111, LUI 0110111.
  - funct3 shift codes.
  - Decoded-entry struct/width localparam.
- One combinational sub-module, imm_gen (instr, XLEN), produces out_imm and the flags.
- decode_stage owns the handshake and the two-entry buffer.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle out_valid=1, rs1=2, rd=1, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0.
- slli x3,x4,5 (0x00521193) -> imm=5; srai x5,x6,31 (0x41F35293) -> imm=31, funct7=0x20.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, uses_rs1=uses_rs2=1, writes_rd=0; lui x1,0x12345 (0x123450B7) -> imm=0x12345000; with XLEN=64, lui 0x80000 -> imm=0xFFFFFFFF80000000.
- out_ready=0, offer 3 instructions back-to-back -> 2 accepted, in_ready=0 from the cycle after the 2nd; raise out_ready -> the two emerge in order on consecutive cycles, the third is then accepted.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction never appears.
- 0x0000007F -> illegal=1, imm=0, flags=0; assert rst mid-stream -> out_valid=0 immediately without a clock edge, in_ready=1 after release.
